// File: rtl/mem_access_unit.sv
// Memory stage behind the 64-bit ALU: byte..doubleword loads/stores over a req/ack bus.
// Optional MEM_TIMEOUT_EN bounds the ACCESS wait to TIMEOUT request cycles.
module mem_access_unit #(
    parameter int MEM_ADDR_W = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Start,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [1:0]            Size,
    input  logic                  SignExt,
    input  logic [63:0]           Address,
    input  logic [63:0]           WriteData,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error,
    output logic [63:0]           ReadData,
    output logic                  MemReq,
    output logic                  MemWe,
    output logic [MEM_ADDR_W-1:0] MemAddr,
    output logic [63:0]           MemWData,
    output logic [7:0]            MemBe,
    input  logic                  MemAck,
    input  logic [63:0]           MemRData
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                state, state_nxt;
    logic [MEM_ADDR_W-1:0] addr_q, addr_nxt;
    logic [63:0]           wdata_q, wdata_nxt;
    logic [1:0]            size_q, size_nxt;
    logic                  sext_q, sext_nxt;
    logic                  write_q, write_nxt;
    logic [63:0]           result_q, result_nxt;
    logic                  err_q, err_nxt;

    logic                  busy_nxt, done_nxt, error_nxt, req_nxt, we_nxt;
    logic [63:0]           readdata_nxt, mwdata_nxt;
    logic [MEM_ADDR_W-1:0] maddr_nxt;
    logic [7:0]            be_nxt;

    logic [2:0]            start_off, off;
    logic                  misaligned, timeout, ack;
    logic [7:0]            base_mask, lane_mask;
    logic [63:0]           rshift, load_val;

    assign start_off = Address[2:0];
    assign off       = addr_q[2:0];
    // MemReq is only ever high in ACCESS, so it also gates acks seen in IDLE/DONE.
    assign ack       = MemReq & MemAck;

    always_comb begin
        case (Size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = start_off[0];
            2'b10:   misaligned = |start_off[1:0];
            default: misaligned = |start_off;
        endcase
    end

    always_comb begin
        rshift = MemRData >> {off, 3'b000};
        case (size_q)
            2'b00: begin
                base_mask = 8'h01;
                load_val  = {{56{sext_q & rshift[7]}}, rshift[7:0]};
            end
            2'b01: begin
                base_mask = 8'h03;
                load_val  = {{48{sext_q & rshift[15]}}, rshift[15:0]};
            end
            2'b10: begin
                base_mask = 8'h0F;
                load_val  = {{32{sext_q & rshift[31]}}, rshift[31:0]};
            end
            default: begin
                base_mask = 8'hFF;
                load_val  = rshift;
            end
        endcase
        lane_mask = base_mask << off;
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] cnt_q;

    // Counts request cycles; the first ACCESS cycle has MemReq still low.
    always_ff @(posedge clk) begin
        if (rst || state != ACCESS) cnt_q <= '0;
        else if (MemReq)            cnt_q <= cnt_q + CNT_W'(1);
    end

    assign timeout = MemReq && (cnt_q == CNT_W'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign timeout        = 1'b0;
`endif

    always_comb begin
        // NOTE: every target is defaulted first so no path through the case infers a latch.
        state_nxt    = state;
        addr_nxt     = addr_q;
        wdata_nxt    = wdata_q;
        size_nxt     = size_q;
        sext_nxt     = sext_q;
        write_nxt    = write_q;
        result_nxt   = result_q;
        err_nxt      = err_q;
        busy_nxt     = (state != IDLE);
        done_nxt     = (state == DONE);
        error_nxt    = (state == DONE) && err_q;
        readdata_nxt = (state == DONE) ? result_q : ReadData;
        req_nxt      = 1'b0;
        we_nxt       = 1'b0;
        maddr_nxt    = '0;
        be_nxt       = '0;
        mwdata_nxt   = '0;

        case (state)
            IDLE: begin
                if (Start) begin
                    addr_nxt  = Address[MEM_ADDR_W-1:0];
                    wdata_nxt = WriteData;
                    size_nxt  = Size;
                    sext_nxt  = SignExt;
                    write_nxt = MemWrite;
                    if (!MemRead && !MemWrite) begin
                        state_nxt  = DONE;
                        result_nxt = Address;
                        err_nxt    = 1'b0;
                    end else if ((MemRead && MemWrite) || misaligned) begin
                        state_nxt  = DONE;
                        result_nxt = '0;
                        err_nxt    = 1'b1;
                    end else begin
                        state_nxt  = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (ack) begin
                    state_nxt  = DONE;
                    result_nxt = write_q ? 64'd0 : load_val;
                    err_nxt    = 1'b0;
                end else if (timeout) begin
                    state_nxt  = DONE;
                    result_nxt = '0;
                    err_nxt    = 1'b1;
                end else begin
                    req_nxt    = 1'b1;
                    we_nxt     = write_q;
                    maddr_nxt  = {addr_q[MEM_ADDR_W-1:3], 3'b000};
                    be_nxt     = lane_mask;
                    mwdata_nxt = write_q ? (wdata_q << {off, 3'b000}) : 64'd0;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values together.
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            size_q   <= '0;
            sext_q   <= 1'b0;
            write_q  <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Error    <= 1'b0;
            ReadData <= '0;
            MemReq   <= 1'b0;
            MemWe    <= 1'b0;
            MemAddr  <= '0;
            MemWData <= '0;
            MemBe    <= '0;
        end else begin
            state    <= state_nxt;
            addr_q   <= addr_nxt;
            wdata_q  <= wdata_nxt;
            size_q   <= size_nxt;
            sext_q   <= sext_nxt;
            write_q  <= write_nxt;
            result_q <= result_nxt;
            err_q    <= err_nxt;
            Busy     <= busy_nxt;
            Done     <= done_nxt;
            Error    <= error_nxt;
            ReadData <= readdata_nxt;
            MemReq   <= req_nxt;
            MemWe    <= we_nxt;
            MemAddr  <= maddr_nxt;
            MemWData <= mwdata_nxt;
            MemBe    <= be_nxt;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: randomized ops, reference model, bus responder.
module tb_mem_access_unit;

    localparam int MEM_ADDR_W = 32;
    localparam int TIMEOUT    = 4;

    logic                  clk, rst;
    logic                  Start, MemRead, MemWrite, SignExt;
    logic [1:0]            Size;
    logic [63:0]           Address, WriteData;
    logic                  Busy, Done, Error;
    logic [63:0]           ReadData;
    logic                  MemReq, MemWe;
    logic [MEM_ADDR_W-1:0] MemAddr;
    logic [63:0]           MemWData;
    logic [7:0]            MemBe;
    logic                  MemAck;
    logic [63:0]           MemRData;

    mem_access_unit #(.MEM_ADDR_W(MEM_ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .Start(Start), .MemRead(MemRead), .MemWrite(MemWrite),
        .Size(Size), .SignExt(SignExt), .Address(Address), .WriteData(WriteData),
        .Busy(Busy), .Done(Done), .Error(Error), .ReadData(ReadData),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemBe(MemBe), .MemAck(MemAck), .MemRData(MemRData)
    );

    typedef struct {
        logic [63:0] rd;
        logic        err;
    } exp_t;

    typedef struct {
        logic [63:0] addr;
        logic        we;
        logic [7:0]  be;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          delay;
    } bus_t;

    exp_t exp_q[$];
    bus_t bus_q[$];
    int   checks = 0;
    int   passed = 0;
    logic rst_at_edge;
    bit   idle_noise = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) rst_at_edge <= rst;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: expected completion and bus transaction from plain arithmetic.
    function automatic void model(input logic rd, input logic wr, input logic [1:0] size,
                                  input logic sext, input logic [63:0] addr,
                                  input logic [63:0] wd, input logic [63:0] rdata,
                                  output exp_t e, output bus_t b, output bit bus_op);
        int          nbytes, off;
        logic [63:0] mask, v;
        nbytes = 1 << size;
        off    = int'(addr % 64'd8);
        b      = '{addr: 64'd0, we: 1'b0, be: 8'd0, wdata: 64'd0, rdata: 64'd0, delay: 0};
        bus_op = 0;
        if (!rd && !wr) begin
            e.rd = addr; e.err = 1'b0;
        end else if ((rd && wr) || (off % nbytes) != 0) begin
            e.rd = 64'd0; e.err = 1'b1;
        end else begin
            bus_op  = 1;
            mask    = (nbytes == 8) ? {64{1'b1}} : ((64'd1 << (8 * nbytes)) - 64'd1);
            b.addr  = (addr & ((64'd1 << MEM_ADDR_W) - 64'd1)) - 64'(off);
            b.we    = wr;
            b.be    = 8'(((1 << nbytes) - 1) << off);
            b.wdata = wr ? (wd << (8 * off)) : 64'd0;
            b.rdata = rdata;
            e.err   = 1'b0;
            if (wr) begin
                e.rd = 64'd0;
            end else begin
                v = (rdata >> (8 * off)) & mask;
                if (sext && nbytes < 8 && v[8 * nbytes - 1]) v = v | ~mask;
                e.rd = v;
            end
        end
    endfunction

    // Monitor: pops the scoreboard whenever the DUT signals completion.
    initial begin
        exp_t        e;
        logic [63:0] last_rd;
        bit          prev_done;
        last_rd   = 64'd0;
        prev_done = 0;
        forever begin
            @(negedge clk);
            if (rst_at_edge === 1'b1) begin
                last_rd   = 64'd0;
                prev_done = 0;
            end
            if (Done === 1'b1) begin
                check("Done single-cycle", 64'(prev_done), 64'd0);
                if (exp_q.size() == 0) begin
                    check("Done with nothing expected", 64'(Done), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("ReadData", ReadData, e.rd);
                    check("Error", 64'(Error), 64'(e.err));
                    check("Busy with Done", 64'(Busy), 64'd1);
                    last_rd = e.rd;
                end
                prev_done = 1;
            end else begin
                check("ReadData hold", ReadData, last_rd);
                prev_done = 0;
            end
        end
    end

    // Bus responder: checks request fields every cycle and acks after the chosen delay.
    initial begin
        bus_t cur;
        bit   active, ack_real;
        int   wait_cnt;
        active   = 0;
        ack_real = 0;
        wait_cnt = 0;
        MemAck   = 1'b0;
        MemRData = 64'd0;
        forever begin
            @(negedge clk);
            if (MemReq === 1'b1) begin
                ack_real = 0;
                if (!active) begin
                    if (bus_q.size() == 0) begin
                        check("MemReq with no bus op expected", 64'(MemReq), 64'd0);
                        MemAck = 1'b0;
                    end else begin
                        cur      = bus_q.pop_front();
                        active   = 1;
                        wait_cnt = cur.delay;
                    end
                end
                if (active) begin
                    check("MemAddr", 64'(MemAddr), cur.addr);
                    check("MemWe", 64'(MemWe), 64'(cur.we));
                    check("MemBe", 64'(MemBe), 64'(cur.be));
                    check("MemWData", MemWData, cur.wdata);
                    if (wait_cnt == 0) begin
                        MemAck   = 1'b1;
                        MemRData = cur.rdata;
                        active   = 0;
                        ack_real = 1;
                    end else begin
                        wait_cnt--;
                        MemAck   = 1'b0;
                        MemRData = {$urandom, $urandom};
                    end
                end
            end else begin
                active = 0;
                if ((ack_real && $urandom_range(0, 1) == 1) || idle_noise) begin
                    MemAck   = 1'b1;
                    MemRData = {$urandom, $urandom};
                end else begin
                    MemAck = 1'b0;
                end
                ack_real = 0;
            end
        end
    end

    task automatic apply_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle_gap();
        idle_noise = ($urandom_range(0, 1) == 1);
        @(negedge clk);
        idle_noise = 0;
        @(negedge clk);
    endtask

    task automatic do_op(input logic rd, input logic wr, input logic [1:0] size, input logic sext,
                         input logic [63:0] addr, input logic [63:0] wd,
                         input logic [63:0] rdata, input int delay);
        exp_t e;
        bus_t b;
        bit   bus_op;
        int   lat_exp, n;
        model(rd, wr, size, sext, addr, wd, rdata, e, b, bus_op);
        b.delay = delay;
        lat_exp = bus_op ? 4 + delay : 2;
`ifdef MEM_TIMEOUT_EN
        if (bus_op && delay >= TIMEOUT) begin
            e.rd    = 64'd0;
            e.err   = 1'b1;
            lat_exp = TIMEOUT + 3;
        end
`endif
        if (bus_op) bus_q.push_back(b);
        exp_q.push_back(e);
        idle_gap();
        Start = 1'b1; MemRead = rd; MemWrite = wr; Size = size; SignExt = sext;
        Address = addr; WriteData = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (Done !== 1'b1) begin
                Start     = ($urandom_range(0, 2) == 0);
                MemRead   = 1'($urandom);
                MemWrite  = 1'($urandom);
                Size      = 2'($urandom);
                SignExt   = 1'($urandom);
                Address   = {$urandom, $urandom};
                WriteData = {$urandom, $urandom};
            end
        end while (Done !== 1'b1 && n < 60);
        Start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        if (Done !== 1'b1) begin
            check("Done within cycle budget", 64'(Done), 64'd1);
            apply_reset(2);
            exp_q.delete();
            bus_q.delete();
        end else begin
            check("Start-to-Done latency", 64'(n), 64'(lat_exp));
        end
    endtask

    task automatic reset_mid_access();
        exp_t e;
        bus_t b;
        bit   bus_op;
        int   n;
        model(1'b1, 1'b0, 2'b11, 1'b0, 64'h0000_0000_0000_0100, 64'd0, 64'd0, e, b, bus_op);
        b.delay = 1000;
        bus_q.push_back(b);
        idle_gap();
        Start = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Size = 2'b11; SignExt = 1'b0;
        Address = 64'h0000_0000_0000_0100;
        @(negedge clk);
        Start = 1'b0; MemRead = 1'b0;
        n = 0;
        while (MemReq !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("MemReq before reset", 64'(MemReq), 64'd1);
        @(negedge clk);
        apply_reset(1);
        bus_q.delete();
        check("MemReq after reset", 64'(MemReq), 64'd0);
        check("Busy after reset", 64'(Busy), 64'd0);
        check("Done after reset", 64'(Done), 64'd0);
        repeat (3) begin
            @(negedge clk);
            check("no Done after abandoned access", 64'(Done), 64'd0);
            check("no MemReq after abandoned access", 64'(MemReq), 64'd0);
        end
    endtask

    initial begin
        int          kind;
        logic        rd, wr, sext;
        logic [1:0]  size;
        logic [2:0]  am;
        logic [63:0] addr;

        Start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Size = 2'b00; SignExt = 1'b0;
        Address = 64'd0; WriteData = 64'd0;
        apply_reset(3);
        check("reset Busy", 64'(Busy), 64'd0);
        check("reset Done", 64'(Done), 64'd0);
        check("reset Error", 64'(Error), 64'd0);
        check("reset ReadData", ReadData, 64'd0);
        check("reset MemReq", 64'(MemReq), 64'd0);
        check("reset MemWe", 64'(MemWe), 64'd0);
        check("reset MemAddr", 64'(MemAddr), 64'd0);
        check("reset MemWData", MemWData, 64'd0);
        check("reset MemBe", 64'(MemBe), 64'd0);

        do_op(1'b0, 1'b0, 2'b00, 1'b0, 64'h1234, 64'd0, 64'd0, 0);
        do_op(1'b0, 1'b1, 2'b00, 1'b0, 64'h5, 64'hAB, 64'd0, 2);
        do_op(1'b1, 1'b0, 2'b01, 1'b1, 64'h2, 64'd0, 64'h0000_0000_F0F0_0000, 1);
        do_op(1'b1, 1'b0, 2'b01, 1'b0, 64'h2, 64'd0, 64'h0000_0000_F0F0_0000, 0);
        do_op(1'b1, 1'b0, 2'b11, 1'b0, 64'h4, 64'd0, 64'd0, 0);
        do_op(1'b1, 1'b1, 2'b10, 1'b0, 64'h8, 64'd0, 64'd0, 0);
        do_op(1'b1, 1'b0, 2'b11, 1'b1, 64'hFFFF_0000_8765_4328, 64'd0, 64'h8123_4567_89AB_CDEF, 3);
        do_op(0, 1'b1, 2'b10, 1'b0, 64'h0000_0001_0000_10AC, 64'h1122_3344_5566_7788, 64'd0, 1);
        do_op(1'b1, 1'b0, 2'b00, 1'b1, 64'h7, 64'd0, 64'h8000_0000_0000_0000, 0);

        reset_mid_access();
        do_op(1'b1, 1'b0, 2'b10, 1'b1, 64'h104, 64'd0, 64'h8765_4321_0000_0000, 2);

`ifdef MEM_TIMEOUT_EN
        do_op(1'b1, 1'b0, 2'b10, 1'b0, 64'h40, 64'd0, 64'h1, 1000);
        do_op(1'b0, 1'b1, 2'b01, 1'b0, 64'h42, 64'hBEEF, 64'd0, TIMEOUT - 1);
`endif

        for (int i = 0; i < 250; i++) begin
            kind = $urandom_range(0, 19);
            if (kind == 0) begin
                rd = 1'b0; wr = 1'b0;
            end else if (kind == 1) begin
                rd = 1'b1; wr = 1'b1;
            end else begin
                rd = (kind % 2 == 0); wr = !rd;
            end
            size = 2'($urandom_range(0, 3));
            sext = 1'($urandom);
            addr = {$urandom, $urandom};
            if ($urandom_range(0, 4) != 0) begin
                am        = 3'((1 << size) - 1);
                addr[2:0] = addr[2:0] & ~am;
            end
            do_op(rd, wr, size, sext, addr, {$urandom, $urandom}, {$urandom, $urandom},
                  $urandom_range(0, 5));
        end

        repeat (4) @(negedge clk);
        check("scoreboard drained", 64'(exp_q.size()), 64'd0);
        check("bus queue drained", 64'(bus_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Memory stage directly downstream of the 64-bit ALU.
- Takes the ALU Result as the effective address and the second register operand as store data.
- Performs byte/half/word/doubleword loads and stores over a req/ack memory bus.
- Returns a 64-bit writeback value: load data, or the ALU result passed through for non-memory ops.
- Multi-cycle; a small FSM holds the operation until memory acknowledges.

Parameters:
MEM_ADDR_W, 32, width of MemAddr; low MEM_ADDR_W bits of Address used, bits [2:0] forced to 0
TIMEOUT, 255, ACCESS-state cycle limit (used only with MEM_TIMEOUT_EN)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
Start  in  1  operation request; sampled only in IDLE
MemRead  in  1  load operation
MemWrite  in  1  store operation
Size  in  2  00 byte, 01 half, 10 word, 11 doubleword
SignExt  in  1  sign-extend load result (ignored for Size=11)
Address  in  64  effective address (ALU Result)
WriteData  in  64  store data, right-aligned
Busy  out  1  high in ACCESS and DONE
Done  out  1  one-cycle completion pulse
Error  out  1  valid while Done=1
ReadData  out  64  writeback value, valid while Done=1, held until next Done
MemReq  out  1  bus request
MemWe  out  1  bus write enable
MemAddr  out  MEM_ADDR_W  doubleword-aligned bus address
MemWData  out  64  lane-aligned store data
MemBe  out  8  byte-lane enables
MemAck  in  1  bus acknowledge; MemRData valid the same cycle
MemRData  in  64  bus read data

Behaviour:
- States: IDLE, ACCESS, DONE. Every output is registered.
- Reset (rst=1 at an edge): state IDLE; all outputs 0, including ReadData. Any outstanding request is abandoned. MemAck after reset is ignored.
- Start=1 in IDLE latches Address, WriteData, Size, SignExt, MemRead and MemWrite. Start outside IDLE is ignored.
- Offset off = Address[2:0]. Misaligned when off is not a multiple of 2^Size bytes.
- IDLE+Start, MemRead=MemWrite=0: go to DONE; ReadData=Address; Error=0; no bus activity.
- IDLE+Start, MemRead=MemWrite=1, or misaligned: go to DONE; Error=1; ReadData=0; no bus activity.
- IDLE+Start, otherwise: go to ACCESS.
  - MemReq=1 on the next cycle.
  - MemAddr = {Address[MEM_ADDR_W-1:3], 3'b000}.
  - MemWe = MemWrite.
- ACCESS, stores:
  - MemBe = ((1<<(1<<Size))-1) << off.
  - MemWData = WriteData << (8*off).
- ACCESS, loads: MemBe holds the same lane mask; MemWData=0.
- ACCESS: MemReq, MemAddr, MemWe, MemBe and MemWData stay stable until MemAck=1 is sampled.
  - On that edge: MemReq drops, go to DONE.
  - Loads: ReadData = (MemRData >> 8*off), truncated to 2^Size bytes, then zero- or sign-extended per SignExt.
  - Stores: ReadData=0.
- DONE: Done=1, Busy=1, for exactly one cycle, then IDLE. Start in DONE is ignored.
- Latency:
  - Start at edge T.
  - MemReq high after T+1.
  - Ack sampled at T+k (k≥2) gives Done after T+k+1.
  - Non-bus ops give Done after T+1.
- MemAck in IDLE or DONE is ignored.
- rst=1 in ACCESS: MemReq drops the next cycle; no Done.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - An 8-bit-or-wider counter clears on ACCESS entry and increments each ACCESS cycle.
  - If it reaches TIMEOUT without MemAck: MemReq drops, go to DONE, Error=1, ReadData=0.
  - Ack and timeout on the same edge: ack wins.
- Undefined: no counter; ACCESS waits indefinitely.

Test Plan:
- Pass-through: Start with MemRead=MemWrite=0, Address=64'h1234 -> Done one cycle later, ReadData=64'h1234, Error=0, MemReq never high.
- Store byte: Address=5, Size=00, WriteData=64'hAB, MemAck after 3 cycles -> MemBe=8'h20, MemWData=64'h0000AB0000000000, MemWe=1, Done 1 cycle after ack.
- Signed load half: Address=2, Size=01, SignExt=1, MemRData=64'h00000000F0F00000 -> ReadData=64'hFFFFFFFFFFFFF0F0; with SignExt=0 -> 64'h000000000000F0F0.
- Misaligned: Address=4, Size=11 -> Error=1, ReadData=0, no MemReq. MemRead=MemWrite=1 -> Error=1.
- Reset mid-access: rst during ACCESS -> MemReq=0 the next cycle, no Done; a following Start completes normally.
- Timeout (MEM_TIMEOUT_EN, TIMEOUT=4): MemAck held 0 -> MemReq high 4 cycles, then Done with Error=1.
